// File: rtl/lieat_exu_vpu_rob.sv
// VPU dispatch steering plus in-order completion buffer: routes micro-ops to
// NUM_FU channels, gathers out-of-order results and retires them in program order.
module lieat_exu_vpu_rob #(
    parameter int NUM_FU  = 3,
    parameter int DEPTH   = 4,
    parameter int XLEN    = 32,
    parameter int REG_IDX = 5,
    parameter int DW      = 32,
    localparam int FUW    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int PTRW   = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush_req,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [FUW-1:0]       disp_fu,
    input  logic [XLEN-1:0]      disp_pc,
    input  logic [REG_IDX-1:0]   disp_rd,
    output logic [NUM_FU-1:0]    fu_i_valid,
    input  logic [NUM_FU-1:0]    fu_i_ready,
    input  logic [NUM_FU-1:0]    fu_o_valid,
    output logic [NUM_FU-1:0]    fu_o_ready,
    input  logic [NUM_FU-1:0]    fu_o_wen,
    input  logic [NUM_FU*DW-1:0] fu_o_data,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [XLEN-1:0]      wb_pc,
    output logic [REG_IDX-1:0]   wb_rd,
    output logic                 wb_wen,
    output logic [DW-1:0]        wb_data,
    output logic [PTRW:0]        occupancy
);

    localparam logic [PTRW:0]   DEPTH_L = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0]   CNT_ONE = (PTRW+1)'(1);
    localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);

    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_done;
    logic [DEPTH-1:0]   r_wen;
    logic [FUW-1:0]     r_fu   [DEPTH];
    logic [XLEN-1:0]    r_pc   [DEPTH];
    logic [REG_IDX-1:0] r_rd   [DEPTH];
    logic [DW-1:0]      r_data [DEPTH];
    logic [PTRW-1:0]    r_head;
    logic [PTRW-1:0]    r_tail;
    logic [PTRW:0]      r_count;

    logic               w_full;
    logic               w_sel_ready;
    logic               w_disp_ok;
    logic               w_disp_fire;
    logic               w_ret_fire;
    logic [NUM_FU-1:0]  w_tgt_found;
    logic [PTRW-1:0]    w_tgt_idx [NUM_FU];
    logic [NUM_FU-1:0]  w_cmp_fire;

    assign w_full    = (r_count == DEPTH_L);
    assign w_disp_ok = disp_valid & ~w_full & ~flush_req;

    // Channel steering; an out-of-range disp_fu matches no channel, so it is never ready.
    always_comb begin
        w_sel_ready = 1'b0;
        fu_i_valid  = {NUM_FU{1'b0}};
        for (int k = 0; k < NUM_FU; k++) begin
            w_sel_ready   = w_sel_ready | (fu_i_ready[k] & (disp_fu == FUW'(k)));
            fu_i_valid[k] = w_disp_ok & (disp_fu == FUW'(k));
        end
    end

    assign disp_ready  = ~w_full & ~flush_req & w_sel_ready;
    assign w_disp_fire = disp_valid & disp_ready;

    // Per-channel completion target: oldest pending entry of that channel, scanning from head.
    always_comb begin
        logic [PTRW-1:0] v_scan;
        logic            v_hit;
        v_scan = {PTRW{1'b0}};
        v_hit  = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            w_tgt_found[k] = 1'b0;
            w_tgt_idx[k]   = {PTRW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                v_scan = r_head + PTRW'(i);
                v_hit  = ~w_tgt_found[k] & r_valid[v_scan] & ~r_done[v_scan] &
                         (r_fu[v_scan] == FUW'(k));
                w_tgt_idx[k]   = v_hit ? v_scan : w_tgt_idx[k];
                w_tgt_found[k] = w_tgt_found[k] | v_hit;
            end
        end
    end

    assign fu_o_ready = w_tgt_found & {NUM_FU{~flush_req}};
    assign w_cmp_fire = fu_o_valid & fu_o_ready;

    // wb_valid is deliberately not gated by flush_req; a flush-cycle retire is still visible.
    assign wb_valid   = r_valid[r_head] & r_done[r_head];
    assign wb_pc      = wb_valid ? r_pc[r_head]   : {XLEN{1'b0}};
    assign wb_rd      = wb_valid ? r_rd[r_head]   : {REG_IDX{1'b0}};
    assign wb_wen     = wb_valid ? r_wen[r_head]  : 1'b0;
    assign wb_data    = wb_valid ? r_data[r_head] : {DW{1'b0}};
    assign w_ret_fire = wb_valid & wb_ready;
    assign occupancy  = r_count;

    // Entry state, pointers and count; flush overrides every same-cycle event.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= {DEPTH{1'b0}};
            r_done  <= {DEPTH{1'b0}};
            r_wen   <= {DEPTH{1'b0}};
            r_head  <= {PTRW{1'b0}};
            r_tail  <= {PTRW{1'b0}};
            r_count <= {(PTRW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_fu[i]   <= {FUW{1'b0}};
                r_pc[i]   <= {XLEN{1'b0}};
                r_rd[i]   <= {REG_IDX{1'b0}};
                r_data[i] <= {DW{1'b0}};
            end
        end else if (flush_req) begin
            r_valid <= {DEPTH{1'b0}};
            r_done  <= {DEPTH{1'b0}};
            r_head  <= {PTRW{1'b0}};
            r_tail  <= {PTRW{1'b0}};
            r_count <= {(PTRW+1){1'b0}};
        end else begin
            if (w_disp_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_fu[r_tail]    <= disp_fu;
                r_pc[r_tail]    <= disp_pc;
                r_rd[r_tail]    <= disp_rd;
                r_tail          <= r_tail + PTR_ONE;
            end
            for (int k = 0; k < NUM_FU; k++) begin
                if (w_cmp_fire[k]) begin
                    r_done[w_tgt_idx[k]] <= 1'b1;
                    r_wen[w_tgt_idx[k]]  <= fu_o_wen[k];
                    r_data[w_tgt_idx[k]] <= fu_o_data[k*DW +: DW];
                end
            end
            if (w_ret_fire) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + PTR_ONE;
            end
            case ({w_disp_fire, w_ret_fire})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_lieat_exu_vpu_rob.sv
// Directed bench for lieat_exu_vpu_rob: ordering, full, wrap, flush and async reset.
module tb_lieat_exu_vpu_rob;

    localparam int NUM_FU  = 3;
    localparam int DEPTH   = 4;
    localparam int XLEN    = 32;
    localparam int REG_IDX = 5;
    localparam int DW      = 32;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 flush_req;
    logic                 disp_valid;
    logic                 disp_ready;
    logic [1:0]           disp_fu;
    logic [XLEN-1:0]      disp_pc;
    logic [REG_IDX-1:0]   disp_rd;
    logic [NUM_FU-1:0]    fu_i_valid;
    logic [NUM_FU-1:0]    fu_i_ready;
    logic [NUM_FU-1:0]    fu_o_valid;
    logic [NUM_FU-1:0]    fu_o_ready;
    logic [NUM_FU-1:0]    fu_o_wen;
    logic [NUM_FU*DW-1:0] fu_o_data;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [XLEN-1:0]      wb_pc;
    logic [REG_IDX-1:0]   wb_rd;
    logic                 wb_wen;
    logic [DW-1:0]        wb_data;
    logic [2:0]           occupancy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    lieat_exu_vpu_rob #(.NUM_FU(NUM_FU), .DEPTH(DEPTH), .XLEN(XLEN), .REG_IDX(REG_IDX), .DW(DW)) dut (
        .clock(clock), .reset(reset), .flush_req(flush_req),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_fu(disp_fu),
        .disp_pc(disp_pc), .disp_rd(disp_rd),
        .fu_i_valid(fu_i_valid), .fu_i_ready(fu_i_ready),
        .fu_o_valid(fu_o_valid), .fu_o_ready(fu_o_ready),
        .fu_o_wen(fu_o_wen), .fu_o_data(fu_o_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_wen(wb_wen), .wb_data(wb_data), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic disp(input int fu, input logic [31:0] pc, input int rd);
        disp_valid = 1'b1;
        disp_fu    = 2'(fu);
        disp_pc    = pc;
        disp_rd    = 5'(rd);
    endtask

    task automatic cmp(input int k, input logic [31:0] d, input logic w);
        fu_o_valid              = 3'b000;
        fu_o_valid[k]           = 1'b1;
        fu_o_wen[k]             = w;
        fu_o_data[k*DW +: DW]   = d;
    endtask

    initial begin
        reset = 1'b0; flush_req = 1'b0; disp_valid = 1'b0; disp_fu = 2'd1;
        disp_pc = 32'h0; disp_rd = 5'd0; fu_i_ready = 3'b101;
        fu_o_valid = 3'b000; fu_o_wen = 3'b000; fu_o_data = {(NUM_FU*DW){1'b0}};
        wb_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_wb_valid", 64'(wb_valid), 64'h0);
        chk("rst_wb_pc", 64'(wb_pc), 64'h0);
        chk("rst_occ", 64'(occupancy), 64'h0);
        chk("rst_fu_o_ready", 64'(fu_o_ready), 64'h0);
        chk("rst_fu_i_valid", 64'(fu_i_valid), 64'h0);
        chk("rst_disp_ready_busy", 64'(disp_ready), 64'h0);
        disp_fu = 2'd2;
        #1 chk("rst_disp_ready_free", 64'(disp_ready), 64'h1);
        fu_i_ready = 3'b111;
        #9 reset = 1'b1;
        cyc();

        // Illegal channel index
        disp(3, 32'h50, 1);
        #1 chk("illegal_disp_ready", 64'(disp_ready), 64'h0);
        chk("illegal_fu_i_valid", 64'(fu_i_valid), 64'h0);
        cyc();
        disp_valid = 1'b0;
        #1 chk("illegal_occ", 64'(occupancy), 64'h0);

        // In-order single channel
        disp(0, 32'h100, 1);
        #1 chk("t1_disp_ready", 64'(disp_ready), 64'h1);
        chk("t1_fu_i_valid", 64'(fu_i_valid), 64'h1);
        cyc();
        disp(0, 32'h104, 2);
        #1 chk("t1_occ1", 64'(occupancy), 64'h1);
        cyc();
        disp(0, 32'h108, 3); cmp(0, 32'hA0, 1'b1);
        #1 chk("t1_fu_o_ready", 64'(fu_o_ready), 64'h1);
        chk("t1_no_wb_yet", 64'(wb_valid), 64'h0);
        cyc();
        disp_valid = 1'b0; cmp(0, 32'hB0, 1'b1);
        #1 chk("t1_wb0_valid", 64'(wb_valid), 64'h1);
        chk("t1_wb0_pc", 64'(wb_pc), 64'h100);
        chk("t1_wb0_rd", 64'(wb_rd), 64'h1);
        chk("t1_wb0_data", 64'(wb_data), 64'hA0);
        chk("t1_occ3", 64'(occupancy), 64'h3);
        cyc();
        cmp(0, 32'hC0, 1'b1);
        #1 chk("t1_wb1_pc", 64'(wb_pc), 64'h104);
        chk("t1_wb1_data", 64'(wb_data), 64'hB0);
        chk("t1_occ2", 64'(occupancy), 64'h2);
        cyc();
        fu_o_valid = 3'b000;
        #1 chk("t1_wb2_valid", 64'(wb_valid), 64'h1);
        chk("t1_wb2_pc", 64'(wb_pc), 64'h108);
        chk("t1_wb2_data", 64'(wb_data), 64'hC0);
        cyc();
        #1 chk("t1_end_wb_valid", 64'(wb_valid), 64'h0);
        chk("t1_end_occ", 64'(occupancy), 64'h0);

        // Out of order across channels
        disp(1, 32'h200, 3);
        cyc();
        disp(0, 32'h204, 4);
        cyc();
        disp_valid = 1'b0; cmp(0, 32'hBEEF, 1'b1);
        #1 chk("t2_fu_o_ready_both", 64'(fu_o_ready), 64'h3);
        cyc();
        cmp(1, 32'hAAAA, 1'b1);
        #1 chk("t2_blocked_wb", 64'(wb_valid), 64'h0);
        chk("t2_fu_o_ready_a", 64'(fu_o_ready), 64'h2);
        cyc();
        fu_o_valid = 3'b000; wb_ready = 1'b0;
        #1 chk("t2_a_valid", 64'(wb_valid), 64'h1);
        chk("t2_a_pc", 64'(wb_pc), 64'h200);
        chk("t2_a_rd", 64'(wb_rd), 64'h3);
        cyc();
        wb_ready = 1'b1;
        #1 chk("t2_a_hold_pc", 64'(wb_pc), 64'h200);
        chk("t2_a_hold_data", 64'(wb_data), 64'hAAAA);
        cyc();
        #1 chk("t2_b_pc", 64'(wb_pc), 64'h204);
        chk("t2_b_rd", 64'(wb_rd), 64'h4);
        chk("t2_b_data", 64'(wb_data), 64'hBEEF);
        cyc();
        #1 chk("t2_end_occ", 64'(occupancy), 64'h0);

        // Full buffer, retire with simultaneous dispatch
        for (int i = 0; i < 4; i++) begin
            disp(2, 32'h300 + 32'(4*i), i);
            cyc();
        end
        disp(2, 32'h310, 9); cmp(2, 32'h1, 1'b1);
        #1 chk("t3_occ_full", 64'(occupancy), 64'h4);
        chk("t3_full_disp_ready", 64'(disp_ready), 64'h0);
        chk("t3_full_fu_i_valid", 64'(fu_i_valid), 64'h0);
        cyc();
        fu_o_valid = 3'b000;
        #1 chk("t3_wb_pc", 64'(wb_pc), 64'h300);
        chk("t3_pop_cycle_disp_ready", 64'(disp_ready), 64'h0);
        cyc();
        #1 chk("t3_occ3", 64'(occupancy), 64'h3);
        chk("t3_next_disp_ready", 64'(disp_ready), 64'h1);
        cyc();
        disp_valid = 1'b0;
        #1 chk("t3_occ_refill", 64'(occupancy), 64'h4);
        flush_req = 1'b1;
        #1 chk("t3_flush_fu_o_ready", 64'(fu_o_ready), 64'h0);
        chk("t3_flush_disp_ready", 64'(disp_ready), 64'h0);
        cyc();
        flush_req = 1'b0;
        #1 chk("t3_flushed_occ", 64'(occupancy), 64'h0);

        // Back-to-back wrap-around
        for (int i = 0; i < 12; i++) begin
            if (i < 10) disp(0, 32'h400 + 32'(4*i), i);
            else disp_valid = 1'b0;
            if (i >= 1 && i <= 10) cmp(0, 32'h1000 + 32'(i-1), 1'b1);
            else fu_o_valid = 3'b000;
            #1;
            if (i >= 2) begin
                chk($sformatf("t4_wb_valid_%0d", i), 64'(wb_valid), 64'h1);
                chk($sformatf("t4_wb_pc_%0d", i), 64'(wb_pc), 64'h400 + 64'(4*(i-2)));
                chk($sformatf("t4_wb_data_%0d", i), 64'(wb_data), 64'h1000 + 64'(i-2));
            end
            cyc();
        end
        #1 chk("t4_end_wb_valid", 64'(wb_valid), 64'h0);
        chk("t4_end_occ", 64'(occupancy), 64'h0);

        // Flush mid-operation with a concurrent completion
        disp(0, 32'h500, 1);
        cyc();
        disp(1, 32'h504, 2);
        cyc();
        disp(0, 32'h508, 3);
        cyc();
        disp_valid = 1'b0; cmp(1, 32'h55, 1'b1);
        cyc();
        fu_o_valid = 3'b000;
        #1 chk("t5_occ3", 64'(occupancy), 64'h3);
        chk("t5_no_wb", 64'(wb_valid), 64'h0);
        flush_req = 1'b1; cmp(0, 32'h66, 1'b1);
        #1 chk("t5_flush_fu_o_ready", 64'(fu_o_ready), 64'h0);
        cyc();
        flush_req = 1'b0;
        #1 chk("t5_post_occ", 64'(occupancy), 64'h0);
        chk("t5_post_wb_valid", 64'(wb_valid), 64'h0);
        chk("t5_late_fu_o_ready", 64'(fu_o_ready), 64'h0);
        fu_o_valid = 3'b000; disp(0, 32'h600, 7);
        cyc();
        disp_valid = 1'b0; cmp(0, 32'h77, 1'b0);
        #1 chk("t5_new_occ", 64'(occupancy), 64'h1);
        cyc();
        fu_o_valid = 3'b000;
        #1 chk("t5_new_pc", 64'(wb_pc), 64'h600);
        chk("t5_new_rd", 64'(wb_rd), 64'h7);
        chk("t5_new_data", 64'(wb_data), 64'h77);
        chk("t5_new_wen", 64'(wb_wen), 64'h0);
        cyc();
        #1 chk("t5_end_occ", 64'(occupancy), 64'h0);

        // Asynchronous reset mid-operation
        disp(0, 32'h700, 1);
        cyc();
        disp(0, 32'h704, 2); cmp(0, 32'h11, 1'b1); wb_ready = 1'b0;
        cyc();
        disp_valid = 1'b0; fu_o_valid = 3'b000;
        #1 chk("t6_pre_wb_pc", 64'(wb_pc), 64'h700);
        chk("t6_pre_occ", 64'(occupancy), 64'h2);
        reset = 1'b0;
        #1 chk("t6_rst_wb_valid", 64'(wb_valid), 64'h0);
        chk("t6_rst_wb_pc", 64'(wb_pc), 64'h0);
        chk("t6_rst_wb_data", 64'(wb_data), 64'h0);
        chk("t6_rst_occ", 64'(occupancy), 64'h0);
        chk("t6_rst_fu_o_ready", 64'(fu_o_ready), 64'h0);
        #1 reset = 1'b1; wb_ready = 1'b1;
        cyc();
        disp(1, 32'h800, 5);
        #1 chk("t6_resume_ready", 64'(disp_ready), 64'h1);
        chk("t6_resume_fu_i_valid", 64'(fu_i_valid), 64'h2);
        cyc();
        disp_valid = 1'b0; cmp(1, 32'h88, 1'b1);
        #1 chk("t6_resume_occ", 64'(occupancy), 64'h1);
        chk("t6_resume_fu_o_ready", 64'(fu_o_ready), 64'h2);
        cyc();
        fu_o_valid = 3'b000;
        #1 chk("t6_resume_pc", 64'(wb_pc), 64'h800);
        chk("t6_resume_rd", 64'(wb_rd), 64'h5);
        chk("t6_resume_data", 64'(wb_data), 64'h88);
        cyc();
        #1 chk("t6_end_occ", 64'(occupancy), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lieat_exu_vpu_rob.md
# lieat_exu_vpu_rob

Parametrised dispatch-steering and in-order completion buffer for the vector execution unit. It routes each accepted VPU micro-op to one of `NUM_FU` functional-unit channels and records it in a `DEPTH`-entry circular buffer. It collects results that arrive out of order across channels and retires them to the single VPU writeback port strictly in program order. It sits between VPU issue and the vector/scalar writeback path, and replaces the fixed three-unit valid-OR writeback merge with ordered, flushable retirement.

## Interface
Parameters:
- `NUM_FU`, 3, number of functional-unit channels (≥1); `FUW = max(1, clog2(NUM_FU))`.
- `DEPTH`, 4, buffer entries, power of two ≥2; `PTRW = clog2(DEPTH)`.
- `XLEN`, 32, PC width.
- `REG_IDX`, 5, destination register index width.
- `DW`, 32, result payload width per channel.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush_req`  in  1  pipeline flush.
- `disp_valid`  in  1  issue offers a micro-op.
- `disp_ready`  out  1  micro-op accepted this cycle when high with `disp_valid`.
- `disp_fu`  in  FUW  target channel index.
- `disp_pc`  in  XLEN  micro-op PC.
- `disp_rd`  in  REG_IDX  destination index.
- `fu_i_valid`  out  NUM_FU  one-hot dispatch strobe per channel.
- `fu_i_ready`  in  NUM_FU  channel can accept.
- `fu_o_valid`  in  NUM_FU  channel result valid.
- `fu_o_ready`  out  NUM_FU  result accepted.
- `fu_o_wen`  in  NUM_FU  result writes a register.
- `fu_o_data`  in  NUM_FU*DW  results, channel k at `[k*DW +: DW]`.
- `wb_valid`  out  1  head result ready to retire.
- `wb_ready`  in  1  writeback accepts.
- `wb_pc`  out  XLEN, `wb_rd`  out  REG_IDX, `wb_wen`  out  1, `wb_data`  out  DW  head entry contents.
- `occupancy`  out  PTRW+1  valid entry count.

## Operation
- Each entry holds: `valid`, `done`, `fu`, `pc`, `rd`, `wen`, `data`. There are head and tail pointers of width PTRW and a count of width PTRW+1. Pointers wrap modulo DEPTH.
- `full = (count == DEPTH)`, `empty = (count == 0)`.
- Dispatch (combinational):
  - `disp_ready = !full & !flush_req & fu_i_ready[disp_fu]`.
  - `fu_i_valid[k] = disp_valid & !full & !flush_req & (disp_fu == k)`.
  - `disp_fu ≥ NUM_FU` is illegal: `disp_ready = 0`, `fu_i_valid = 0`.
  - On dispatch fire, the entry at tail is written with `valid=1`, `done=0`, `fu`, `pc`, `rd`, and tail increments.
  - A full buffer blocks dispatch even when a pop happens in the same cycle; there is no bypass.
- Completion:
  - Each channel returns results in its own dispatch order.
  - For channel k, the target is the oldest entry, searched from head, with `valid & !done & fu==k`.
  - `fu_o_ready[k] = target exists & !flush_req`.
  - On `fu_o_valid[k] & fu_o_ready[k]`, the target gets `done=1`, `wen=fu_o_wen[k]`, `data=fu_o_data[k]`.
  - Multiple channels may complete in the same cycle; each updates a distinct entry.
- Retire:
  - `wb_valid = entry[head].valid & entry[head].done`.
  - `wb_*` show the head fields. When `wb_valid` is low they are driven to 0.
  - On `wb_valid & wb_ready`, head clears `valid`/`done` and increments.
- count: +1 on dispatch, −1 on retire; unchanged when both or neither occur.
- Flush: `flush_req` high at an edge clears all `valid`/`done` bits, sets head=tail=count=0, and discards any same-cycle dispatch, completion or retire.
  - `wb_valid` is not masked combinationally by `flush_req`. A retire handshaken in the flush cycle is still seen by the consumer, but it does not alter state beyond the flush.

## Timing
- Reset (asynchronous, while `reset`=0): all entries invalid, head=tail=count=0.
  - `wb_valid=0`, `wb_pc/wb_rd/wb_wen/wb_data=0`, `occupancy=0`, `fu_o_ready=0`, `fu_i_valid=0`.
  - `disp_ready` follows `fu_i_ready[disp_fu]` combinationally.
- Dispatch at edge N makes the entry visible from N+1.
- Completion accepted at edge M: `wb_valid` is high in cycle M+1 if the entry is at head. There is no same-cycle completion-to-writeback bypass.
- Sustained throughput is one dispatch and one retire per cycle while neither full nor stalled.
- Once `wb_valid` is asserted, it and `wb_*` stay stable until `wb_ready` or flush.
- `occupancy` is registered and equals count.

## Test plan
- In-order single channel: DEPTH=4, dispatch 3 ops to FU0 (pc 0x100/0x104/0x108), complete each 2 cycles later -> retires in pc order, each `wb_valid` one cycle after its completion, final `occupancy=0`.
- Out-of-order across channels: dispatch A→FU1 (rd 3), then B→FU0 (rd 4); FU0 completes B first with data 0xBEEF -> no `wb_valid` until A completes. A then retires, then B with `wb_data=0xBEEF`.
- Full: fill 4 entries without completions -> `occupancy=4` and `disp_ready=0`. Retire head with a simultaneous `disp_valid` -> the new op is accepted only the following cycle.
- Wrap-around: 10 back-to-back dispatch/complete/retire cycles on DEPTH=4 -> pc sequence preserved across pointer wrap, no lost or duplicated retire.
- Flush mid-operation: 3 entries, one done, `flush_req` pulsed together with a `fu_o_valid` -> next cycle `occupancy=0` and `wb_valid=0`, and the late completion is ignored.
- Reset mid-operation: drop `reset` with 2 entries pending -> all outputs reach reset values immediately (asynchronously), and dispatch resumes normally after release.
